move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_move_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: turns frame-paced gravity ticks and player key edges into a one-deep op/ack stream.
// Build macro MOVE_SCHEDULER_SOFT_DROP_EN adds soft drop (1-frame period while key_drop is held).
module move_scheduler #(
  parameter int unsigned BASE_PERIOD = 48,
  parameter int unsigned MIN_PERIOD  = 4,
  parameter int unsigned STEP        = 4,
  parameter int unsigned LEVEL_MAX   = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vsync,
  input  logic       game_active,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rotate,
  input  logic       key_drop,
  input  logic [7:0] score,
  input  logic       op_ack,
  output logic [3:0] op,
  output logic       op_valid,
  output logic [3:0] level,
  output logic       tick_overrun
);
  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_LEFT   = 4'd1;
  localparam logic [3:0] OP_RIGHT  = 4'd2;
  localparam logic [3:0] OP_ROTATE = 4'd3;
  localparam logic [3:0] OP_FALL   = 4'd5;

  localparam int unsigned P_MAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
  localparam int unsigned CNT_W = $clog2(P_MAX + 1);

  localparam int P_RIGHT = 0;
  localparam int P_LEFT  = 1;
  localparam int P_ROT   = 2;
  localparam int P_FALL  = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ISSUE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             vs_meta_q, vs_meta_d;
  logic             vs_sync_q, vs_sync_d;
  logic             vs_prev_q, vs_prev_d;
  logic [3:0]       level_q, level_d;
  logic [2:0]       keys_prev_q, keys_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       op_q, op_d;
  logic             op_valid_q, op_valid_d;
  logic             ovr_q, ovr_d;

  logic             frame_pulse;
  logic             tick;
  logic             drop_release;
  logic [7:0]       score_lvl;
  logic [3:0]       level_now;
  logic [2:0]       keys_now;
  logic [2:0]       key_rise;
  logic [31:0]      step_total;
  logic [31:0]      period;
  logic [31:0]      base_period_m1;
  logic [31:0]      period_m1;

  // Period derives from the registered level; clamping before the subtraction keeps it from wrapping.
  always_comb begin
    score_lvl  = score >> 3;
    level_now  = (32'(score_lvl) > LEVEL_MAX) ? 4'(LEVEL_MAX) : score_lvl[3:0];
    step_total = 32'(level_q) * STEP;
    if (step_total >= BASE_PERIOD) begin
      period = MIN_PERIOD;
    end else if (BASE_PERIOD - step_total > MIN_PERIOD) begin
      period = BASE_PERIOD - step_total;
    end else begin
      period = MIN_PERIOD;
    end
    base_period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
  end

`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
  logic drop_prev_q, drop_prev_d;

  assign drop_prev_d  = key_drop;
  assign drop_release = drop_prev_q & ~key_drop;
  assign period_m1    = key_drop ? 32'd0 : base_period_m1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_prev_q <= 1'b0;
    else       drop_prev_q <= drop_prev_d;
  end
`else
  logic unused_key_drop;

  assign unused_key_drop = key_drop;
  assign drop_release    = 1'b0;
  assign period_m1       = base_period_m1;
`endif

  always_comb begin
    vs_meta_d   = vsync;
    vs_sync_d   = vs_meta_q;
    vs_prev_d   = vs_sync_q;
    frame_pulse = vs_sync_q & ~vs_prev_q;

    keys_now    = {key_rotate, key_left, key_right};
    key_rise    = frame_pulse ? (keys_now & ~keys_prev_q) : 3'b000;
    keys_prev_d = frame_pulse ? keys_now : keys_prev_q;
    level_d     = frame_pulse ? level_now : level_q;

    // >= rather than == so a level-up that shortens the period cannot strand the counter past it
    tick = frame_pulse && (state_q != IDLE) && (32'(cnt_q) >= period_m1);

    state_d    = state_q;
    pend_d     = pend_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;

    if (tick)             cnt_d = '0;
    else if (frame_pulse) cnt_d = cnt_q + CNT_W'(1);
    if (drop_release)     cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (game_active) state_d = RUN;
      end
      RUN: begin
        if ((|pend_q) && !op_valid_q) begin
          state_d    = ISSUE;
          op_valid_d = 1'b1;
          if (pend_q[P_FALL]) begin
            op_d           = OP_FALL;
            pend_d[P_FALL] = 1'b0;
          end else if (pend_q[P_ROT]) begin
            op_d          = OP_ROTATE;
            pend_d[P_ROT] = 1'b0;
          end else if (pend_q[P_LEFT]) begin
            op_d           = OP_LEFT;
            pend_d[P_LEFT] = 1'b0;
          end else begin
            op_d            = OP_RIGHT;
            pend_d[P_RIGHT] = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (op_ack && op_valid_q) begin
          state_d    = RUN;
          op_valid_d = 1'b0;
          op_d       = OP_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New events are applied after the grant so one arriving on the granted bit is not lost.
    if (tick) begin
      ovr_d          = ovr_q | pend_q[P_FALL];
      pend_d[P_FALL] = 1'b1;
    end
    if (key_rise[2])                 pend_d[P_ROT]   = 1'b1;
    if (key_rise[1] && !key_rise[0]) pend_d[P_LEFT]  = 1'b1;
    if (key_rise[0] && !key_rise[1]) pend_d[P_RIGHT] = 1'b1;

    if (!game_active || state_q == IDLE) begin
      if (!game_active) state_d = IDLE;
      cnt_d      = '0;
      pend_d     = '0;
      op_d       = OP_NONE;
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vs_meta_q   <= 1'b0;
      vs_sync_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      level_q     <= '0;
      keys_prev_q <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      op_q        <= OP_NONE;
      op_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_meta_q   <= vs_meta_d;
      vs_sync_q   <= vs_sync_d;
      vs_prev_q   <= vs_prev_d;
      level_q     <= level_d;
      keys_prev_q <= keys_prev_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign op           = op_q;
  assign op_valid     = op_valid_q;
  assign level        = level_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and randomized frames checked against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_move_scheduler;
  localparam int BASE     = 48;
  localparam int MINP     = 4;
  localparam int STEPP    = 4;
  localparam int LMAX     = 11;
  localparam int FRAME_HI = 16;
  localparam int FRAME_LO = 24;
`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       game_active = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_rotate = 1'b0;
  logic       key_drop = 1'b0;
  logic [7:0] score = 8'd0;
  logic       op_ack = 1'b0;
  logic [3:0] op;
  logic       op_valid;
  logic [3:0] level;
  logic       tick_overrun;

  move_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .game_active (game_active),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_rotate  (key_rotate),
    .key_drop    (key_drop),
    .score       (score),
    .op_ack      (op_ack),
    .op          (op),
    .op_valid    (op_valid),
    .level       (level),
    .tick_overrun(tick_overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Model state. Pending index order is the issue priority: FALL, ROTATE, LEFT, RIGHT.
  int       pri_code[4] = '{5, 3, 1, 2};
  bit [3:0] m_pend = '0;
  int       m_level = 0;
  int       m_cnt = 0;
  bit       m_out = 1'b0;
  bit       m_ovr = 1'b0;
  bit       m_drop_prev = 1'b0;
  bit [2:0] m_kprev = '0;
  bit       ack_en = 1'b0;
  int       frame_no = 0;
  int       exp_q[$];
  int       obs_q[$];

  function automatic int model_period();
    int p;
    p = BASE - m_level * STEPP;
    if (p < MINP) p = MINP;
    if (SOFT_EN && key_drop) p = 1;
    return p;
  endfunction

  task automatic model_issue();
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i]) begin
        exp_q.push_back(pri_code[i]);
        m_pend[i] = 1'b0;
        m_out = 1'b1;
        return;
      end
    end
  endtask

  // With a responsive engine everything pending drains; otherwise one op stays outstanding.
  task automatic model_drain();
    if (ack_en) begin
      m_out = 1'b0;
      while (m_pend != 4'b0) begin
        model_issue();
        m_out = 1'b0;
      end
    end else if (!m_out && m_pend != 4'b0) begin
      model_issue();
    end
  endtask

  task automatic model_frame();
    int       p;
    bit [2:0] keys;
    bit [2:0] rise;
    if (SOFT_EN && m_drop_prev && !key_drop) m_cnt = 0;
    m_drop_prev = key_drop;
    p    = model_period();
    keys = {key_rotate, key_left, key_right};
    rise = keys & ~m_kprev;
    m_kprev = keys;
    if (game_active) begin
      m_cnt++;
      if (m_cnt >= p) begin
        m_cnt = 0;
        if (m_pend[0]) m_ovr = 1'b1;
        m_pend[0] = 1'b1;
      end
      if (rise[2]) m_pend[1] = 1'b1;
      if (rise[1] && !rise[0]) m_pend[2] = 1'b1;
      if (rise[0] && !rise[1]) m_pend[3] = 1'b1;
      model_drain();
    end
    m_level = (int'(score) / 8 > LMAX) ? LMAX : int'(score) / 8;
  endtask

  task automatic compare_state();
    int o;
    int e;
    check("op_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      $display("frame %0d: op %0d issued (model %0d)", frame_no, o, e);
      check("op_code", o, e);
    end
    obs_q.delete();
    exp_q.delete();
    check("level", int'(level), m_level);
    check("tick_overrun", int'(tick_overrun), int'(m_ovr));
    check("op_valid", int'(op_valid), int'(m_out));
  endtask

  task automatic run_frame();
    model_frame();
    vsync = 1'b1;
    repeat (FRAME_HI) @(negedge clock);
    vsync = 1'b0;
    repeat (FRAME_LO) @(negedge clock);
    frame_no++;
    compare_state();
  endtask

  task automatic set_ack(input bit v);
    ack_en = v;
    if (v) begin
      model_drain();
      repeat (30) @(negedge clock);
      compare_state();
    end
  endtask

  task automatic set_active(input bit v);
    game_active = v;
    if (!v) begin
      m_cnt  = 0;
      m_pend = '0;
      m_out  = 1'b0;
    end
    repeat (3) @(negedge clock);
    if (!v) check("inactive_drop", int'(op_valid), 0);
  endtask

  // Engine stand-in: acknowledges 2 clocks after it first sees op_valid.
  initial begin
    forever begin
      @(negedge clock);
      if (ack_en && op_valid && !reset) begin
        repeat (2) @(negedge clock);
        op_ack = 1'b1;
        @(negedge clock);
        op_ack = 1'b0;
      end
    end
  end

  // Op monitor: records each new op and checks it holds steady while valid.
  bit         valid_seen = 1'b0;
  logic [3:0] held_op = '0;
  initial begin
    forever begin
      @(negedge clock);
      if (op_valid && !valid_seen) begin
        obs_q.push_back(int'(op));
        held_op = op;
      end else if (op_valid) begin
        check("op_stable", int'(op), int'(held_op));
      end
      valid_seen = op_valid;
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_op", int'(op), 0);
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_overrun", int'(tick_overrun), 0);
    reset = 1'b0;
    @(negedge clock);

    // Level 0: FALL once every 48 frames.
    ack_en = 1'b1;
    set_active(1'b1);
    for (int f = 0; f < 100; f++) run_frame();

    // Top speed and saturation.
    score = 8'd200;
    for (int f = 0; f < 12; f++) run_frame();
    check("level_200", int'(level), 11);
    score = 8'd255;
    for (int f = 0; f < 4; f++) run_frame();
    check("level_255", int'(level), 11);

    // Rotate and left rising on a gravity-tick frame.
    for (int f = 0; f < 8; f++) begin
      if (m_cnt + 1 >= model_period()) begin
        key_rotate = 1'b1;
        key_left   = 1'b1;
        run_frame();
        break;
      end
      run_frame();
    end
    key_rotate = 1'b0;
    key_left   = 1'b0;
    run_frame();

    // Left and right together, then a stalled engine.
    score = 8'd0;
    run_frame();
    key_left  = 1'b1;
    key_right = 1'b1;
    run_frame();
    key_left  = 1'b0;
    key_right = 1'b0;
    set_ack(1'b0);
    for (int f = 0; f < 150; f++) run_frame();
    check("held_op", int'(op), 5);
    check("overrun_set", int'(tick_overrun), 1);

    // Game stops with an op outstanding.
    set_active(1'b0);
    set_active(1'b1);
    set_ack(1'b1);

    // Soft drop held then released.
    key_drop = 1'b1;
    for (int f = 0; f < 10; f++) run_frame();
    key_drop = 1'b0;
    for (int f = 0; f < 50; f++) run_frame();

    // Reset with an op in flight, followed by a stray ack.
    set_ack(1'b0);
    score = 8'd200;
    for (int f = 0; f < 20 && !m_out; f++) run_frame();
    check("valid_before_reset", int'(op_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_op_valid", int'(op_valid), 0);
    check("rst_mid_op", int'(op), 0);
    check("rst_mid_level", int'(level), 0);
    check("rst_mid_overrun", int'(tick_overrun), 0);
    m_level = 0; m_cnt = 0; m_pend = '0; m_out = 1'b0; m_ovr = 1'b0;
    m_kprev = '0; m_drop_prev = 1'b0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clock);
    reset  = 1'b0;
    op_ack = 1'b1;
    repeat (2) @(negedge clock);
    op_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("late_ack_ignored", int'(op_valid), 0);
    set_ack(1'b1);

    // Randomized frames.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 3) == 0) key_left   = ~key_left;
      if ($urandom_range(0, 3) == 0) key_right  = ~key_right;
      if ($urandom_range(0, 3) == 0) key_rotate = ~key_rotate;
      if ($urandom_range(0, 9) == 0) key_drop   = ~key_drop;
      if ($urandom_range(0, 19) == 0) score = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 24) == 0) set_ack(~ack_en);
      if ($urandom_range(0, 29) == 0) set_active(~game_active);
      run_frame();
    end
    set_ack(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
